// File: rtl/fractal_up_regs_if.sv
// fractal_up_regs_if: byte-wide uP register bus between host and fractal register slave
// Signals: pi_blk_sel, pi_addr[3:0], pi_wr_en, pi_rd_en, pi_wr_data[7:0] (host -> slave);
//          pi_rd_data[7:0], interrupt (slave -> host); interrupt_ack (host -> slave).
// Modports: master (host side), slave (register block side).
interface fractal_up_regs_if;
    logic       pi_blk_sel;
    logic [3:0] pi_addr;
    logic       pi_wr_en;
    logic       pi_rd_en;
    logic [7:0] pi_wr_data;
    logic [7:0] pi_rd_data;
    logic       interrupt;
    logic       interrupt_ack;

    modport master (
        output pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en, pi_wr_data, interrupt_ack,
        input  pi_rd_data, interrupt
    );

    modport slave (
        input  pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en, pi_wr_data, interrupt_ack,
        output pi_rd_data, interrupt
    );
endinterface

// File: rtl/fractal_up_regs.sv
// fractal_up_regs: uP register slave that loads coordinates, starts the fractal engine and reports its result
// Ports: clk, rst_n (async assert, active-low);
//        up            fractal_up_regs_if.slave - host register bus plus interrupt/ack;
//        core_start    one-cycle start pulse to the engine;
//        core_x/core_y committed 16-bit coordinates; core_max_iter iteration limit;
//        core_done     engine completion pulse; core_iter result valid with core_done.
// Option: define UP_REG_RDBACK_EN to read back committed X/Y bytes (addr 0-3) and MAX_ITER (addr 4);
//         otherwise those addresses are write-only and read 0.
module fractal_up_regs #(
    parameter int         ITER_W   = 8,
    parameter logic [7:0] BLOCK_ID = 8'hF5
) (
    input  logic              clk,
    input  logic              rst_n,
    fractal_up_regs_if.slave  up,
    output logic              core_start,
    output logic [15:0]       core_x,
    output logic [15:0]       core_y,
    output logic [ITER_W-1:0] core_max_iter,
    input  logic              core_done,
    input  logic [ITER_W-1:0] core_iter
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [7:0]        x_lo_q, x_lo_d, y_lo_q, y_lo_d, rd_data_q, rd_data_d, rd_mux;
    logic [15:0]       core_x_q, core_x_d, core_y_q, core_y_d;
    logic [ITER_W-1:0] max_iter_q, max_iter_d, result_q, result_d;
    logic              irq_en_q, irq_en_d, irq_pend_q, irq_pend_d;
    logic              start_err_q, start_err_d, core_start_q, core_start_d;
    logic              wr, rd, ctrl_wr, start_ok, fin;

    always_comb begin
        wr           = up.pi_blk_sel & up.pi_wr_en;
        // write wins when both strobes are high, so the read is suppressed
        rd           = up.pi_blk_sel & up.pi_rd_en & ~up.pi_wr_en;
        ctrl_wr      = wr & (up.pi_addr == 4'h5);
        start_ok     = ctrl_wr & up.pi_wr_data[0] & (state_q != RUN);
        fin          = core_done & (state_q == RUN);
        x_lo_d       = (wr && up.pi_addr == 4'h0) ? up.pi_wr_data : x_lo_q;
        core_x_d     = (wr && up.pi_addr == 4'h1) ? {up.pi_wr_data, x_lo_q} : core_x_q;
        y_lo_d       = (wr && up.pi_addr == 4'h2) ? up.pi_wr_data : y_lo_q;
        core_y_d     = (wr && up.pi_addr == 4'h3) ? {up.pi_wr_data, y_lo_q} : core_y_q;
        max_iter_d   = (wr && up.pi_addr == 4'h4) ? up.pi_wr_data[ITER_W-1:0] : max_iter_q;
        irq_en_d     = ctrl_wr ? up.pi_wr_data[1] : irq_en_q;
        // a start while running is dropped and flagged; a CTRL write without start clears the flag
        start_err_d  = ctrl_wr ? (up.pi_wr_data[0] ? (start_err_q | (state_q == RUN)) : 1'b0) : start_err_q;
        core_start_d = start_ok;
        state_d      = start_ok ? RUN : fin ? DONE : state_q;
        result_d     = fin ? core_iter : result_q;
        // a fresh completion outranks a coincident acknowledge
        irq_pend_d   = (fin & irq_en_q) | (irq_pend_q & ~up.interrupt_ack);
        rd_mux       = '0;
        case (up.pi_addr)
`ifdef UP_REG_RDBACK_EN
            4'h0:    rd_mux = core_x_q[7:0];
            4'h1:    rd_mux = core_x_q[15:8];
            4'h2:    rd_mux = core_y_q[7:0];
            4'h3:    rd_mux = core_y_q[15:8];
            4'h4:    rd_mux = 8'(max_iter_q);
`endif
            4'h5:    rd_mux = {6'b0, irq_en_q, 1'b0};
            4'h6:    rd_mux = {4'b0, start_err_q, irq_pend_q, state_q == DONE, state_q == RUN};
            4'h7:    rd_mux = 8'(result_q);
            4'hF:    rd_mux = BLOCK_ID;
            default: rd_mux = '0;
        endcase
        rd_data_d    = rd ? rd_mux : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_lo_q       <= '0;
            y_lo_q       <= '0;
            core_x_q     <= '0;
            core_y_q     <= '0;
            max_iter_q   <= '0;
            result_q     <= '0;
            irq_en_q     <= 1'b0;
            irq_pend_q   <= 1'b0;
            start_err_q  <= 1'b0;
            core_start_q <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            x_lo_q       <= x_lo_d;
            y_lo_q       <= y_lo_d;
            core_x_q     <= core_x_d;
            core_y_q     <= core_y_d;
            max_iter_q   <= max_iter_d;
            result_q     <= result_d;
            irq_en_q     <= irq_en_d;
            irq_pend_q   <= irq_pend_d;
            start_err_q  <= start_err_d;
            core_start_q <= core_start_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign core_start    = core_start_q;
    assign core_x        = core_x_q;
    assign core_y        = core_y_q;
    assign core_max_iter = max_iter_q;
    assign up.pi_rd_data = rd_data_q;
    assign up.interrupt  = irq_pend_q;
endmodule

// File: tb/tb_fractal_up_regs.sv
// tb_fractal_up_regs: randomized self-checking bench for fractal_up_regs against a register-level model
module tb_fractal_up_regs;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_start;
    logic [15:0] core_x, core_y;
    logic [7:0]  core_max_iter;
    logic        core_done = 1'b0;
    logic [7:0]  core_iter = '0;
    int          n_vec = 0;
    int          n_err = 0;

    fractal_up_regs_if bus();

    fractal_up_regs #(.ITER_W(8), .BLOCK_ID(8'hF5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .up            (bus),
        .core_start    (core_start),
        .core_x        (core_x),
        .core_y        (core_y),
        .core_max_iter (core_max_iter),
        .core_done     (core_done),
        .core_iter     (core_iter)
    );

    always #5 clk = ~clk;

    // register-level reference model
    logic [15:0] m_x, m_y;
    logic [7:0]  m_xlo, m_ylo, m_max, m_res, m_rdq;
    bit          m_irq_en, m_busy, m_done, m_irq, m_err, m_start;

    function automatic void m_reset();
        m_x = 0; m_y = 0; m_xlo = 0; m_ylo = 0; m_max = 0; m_res = 0; m_rdq = 0;
        m_irq_en = 0; m_busy = 0; m_done = 0; m_irq = 0; m_err = 0; m_start = 0;
    endfunction

    function automatic logic [7:0] m_read(input logic [3:0] a);
        case (a)
`ifdef UP_REG_RDBACK_EN
            4'h0: return m_x[7:0];
            4'h1: return m_x[15:8];
            4'h2: return m_y[7:0];
            4'h3: return m_y[15:8];
            4'h4: return m_max;
`endif
            4'h5: return {6'b0, m_irq_en, 1'b0};
            4'h6: return {4'b0, m_err, m_irq, m_done, m_busy};
            4'h7: return m_res;
            4'hF: return 8'hF5;
            default: return 8'h00;
        endcase
    endfunction

    function automatic void m_write(input logic [3:0] a, input logic [7:0] d);
        case (a)
            4'h0: m_xlo = d;
            4'h1: m_x = {d, m_xlo};
            4'h2: m_ylo = d;
            4'h3: m_y = {d, m_ylo};
            4'h4: m_max = d;
            4'h5: begin
                m_irq_en = d[1];
                if (!d[0]) m_err = 0;
                else if (m_busy) m_err = 1;
                else begin m_busy = 1; m_done = 0; m_start = 1; end
            end
            default: ;
        endcase
    endfunction

    function automatic void m_cycle(input bit dn, input logic [7:0] it, input bit ak);
        bit nirq;
        m_start = 0;
        nirq = (dn && m_busy && m_irq_en) || (m_irq && !ak);
        if (dn && m_busy) begin m_busy = 0; m_done = 1; m_res = it; end
        m_irq = nirq;
    endfunction

    // one bus cycle, starting and ending on a falling edge
    task automatic acc(input bit sel, input bit we, input bit re, input logic [3:0] a, input logic [7:0] d);
        bus.pi_blk_sel = sel; bus.pi_wr_en = we; bus.pi_rd_en = re; bus.pi_addr = a; bus.pi_wr_data = d;
        @(negedge clk);
        bus.pi_blk_sel = 0; bus.pi_wr_en = 0; bus.pi_rd_en = 0;
        m_start = 0;
        if (sel && re && !we) m_rdq = m_read(a);
        if (sel && we) m_write(a, d);
    endtask

    task automatic eng(input bit dn, input logic [7:0] it, input bit ak);
        core_done = dn; core_iter = it; bus.interrupt_ack = ak;
        @(negedge clk);
        core_done = 0; bus.interrupt_ack = 0;
        m_cycle(dn, it, ak);
    endtask

    task automatic test_reset();
        n_vec++;
        if ({core_start, bus.interrupt, core_x, core_y, core_max_iter, bus.pi_rd_data} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got start=%b irq=%b x=%h y=%h max=%h rd=%h want all 0",
                     core_start, bus.interrupt, core_x, core_y, core_max_iter, bus.pi_rd_data);
        end
        for (int a = 0; a < 16; a++) begin
            acc(1, 0, 1, 4'(a), 8'h00);
            n_vec++;
            if (bus.pi_rd_data !== (a == 15 ? 8'hF5 : 8'h00)) begin
                n_err++;
                $display("FAIL reset_read addr %0h: got %h want %h", a, bus.pi_rd_data, a == 15 ? 8'hF5 : 8'h00);
            end
        end
        n_vec++;
        if (bus.interrupt !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", bus.interrupt); end
    endtask

    task automatic test_coords();
        acc(1, 1, 0, 4'h0, 8'h34);
        n_vec++;
        if (core_x !== 16'h0000) begin n_err++; $display("FAIL x_lo_shadow: got %h want 0000", core_x); end
        acc(1, 1, 0, 4'h1, 8'h12);
        n_vec++;
        if (core_x !== 16'h1234) begin n_err++; $display("FAIL x_commit: got %h want 1234", core_x); end
        for (int i = 0; i < 24; i++) begin
            acc(1, 1, 0, 4'($urandom_range(0, 4)), 8'($urandom));
            n_vec++;
            if ({core_x, core_y, core_max_iter} !== {m_x, m_y, m_max}) begin
                n_err++;
                $display("FAIL coord_rand %0d: got x=%h y=%h max=%h want x=%h y=%h max=%h",
                         i, core_x, core_y, core_max_iter, m_x, m_y, m_max);
            end
        end
    endtask

    task automatic test_start_done();
        acc(1, 1, 0, 4'h5, 8'h03);
        n_vec++;
        if (core_start !== 1'b1) begin n_err++; $display("FAIL start_pulse: got %b want 1", core_start); end
        eng(0, 8'h00, 0);
        n_vec++;
        if (core_start !== 1'b0) begin n_err++; $display("FAIL start_width: got %b want 0", core_start); end
        acc(1, 0, 1, 4'h6, 8'h00);
        n_vec++;
        if (bus.pi_rd_data !== 8'h01) begin n_err++; $display("FAIL status_busy: got %h want 01", bus.pi_rd_data); end
        eng(1, 8'h2A, 0);
        n_vec++;
        if (bus.interrupt !== 1'b1) begin n_err++; $display("FAIL irq_rise: got %b want 1", bus.interrupt); end
        acc(1, 0, 1, 4'h7, 8'h00);
        n_vec++;
        if (bus.pi_rd_data !== 8'h2A) begin n_err++; $display("FAIL result: got %h want 2A", bus.pi_rd_data); end
        acc(1, 0, 1, 4'h6, 8'h00);
        n_vec++;
        if (bus.pi_rd_data !== 8'h06) begin n_err++; $display("FAIL status_done: got %h want 06", bus.pi_rd_data); end
    endtask

    task automatic test_irq_ack();
        eng(0, 8'h00, 1);
        n_vec++;
        if (bus.interrupt !== 1'b0) begin n_err++; $display("FAIL irq_ack: got %b want 0", bus.interrupt); end
        acc(1, 1, 0, 4'h5, 8'h03);
        eng(1, 8'h55, 0);
        acc(1, 1, 0, 4'h5, 8'h03);
        eng(1, 8'h66, 1);
        n_vec++;
        if (bus.interrupt !== 1'b1) begin n_err++; $display("FAIL ack_vs_done: got %b want 1", bus.interrupt); end
        acc(1, 0, 1, 4'h7, 8'h00);
        n_vec++;
        if (bus.pi_rd_data !== 8'h66) begin n_err++; $display("FAIL result2: got %h want 66", bus.pi_rd_data); end
        acc(1, 1, 0, 4'h5, 8'h00);
        n_vec++;
        if (bus.interrupt !== 1'b1) begin n_err++; $display("FAIL irq_en_clear_keeps: got %b want 1", bus.interrupt); end
        eng(0, 8'h00, 1);
        acc(1, 1, 0, 4'h5, 8'h02);
        eng(1, 8'h77, 0);
        acc(1, 0, 1, 4'h7, 8'h00);
        n_vec++;
        if ({bus.interrupt, bus.pi_rd_data} !== {1'b0, 8'h66}) begin
            n_err++;
            $display("FAIL done_outside_run: got irq=%b res=%h want irq=0 res=66", bus.interrupt, bus.pi_rd_data);
        end
    endtask

    task automatic test_start_err();
        acc(1, 1, 0, 4'h5, 8'h01);
        eng(0, 8'h00, 0);
        acc(1, 1, 0, 4'h5, 8'h01);
        n_vec++;
        if (core_start !== 1'b0) begin n_err++; $display("FAIL busy_start_dropped: got %b want 0", core_start); end
        acc(1, 0, 1, 4'h6, 8'h00);
        n_vec++;
        if (bus.pi_rd_data !== 8'h09) begin n_err++; $display("FAIL start_err_set: got %h want 09", bus.pi_rd_data); end
        acc(1, 1, 0, 4'h5, 8'h00);
        acc(1, 0, 1, 4'h6, 8'h00);
        n_vec++;
        if (bus.pi_rd_data !== 8'h01) begin n_err++; $display("FAIL start_err_clear: got %h want 01", bus.pi_rd_data); end
        eng(1, 8'h10, 0);
        n_vec++;
        if (bus.interrupt !== 1'b0) begin n_err++; $display("FAIL irq_masked: got %b want 0", bus.interrupt); end
    endtask

    task automatic test_bus_qualify();
        acc(1, 0, 1, 4'hF, 8'h00);
        acc(1, 1, 1, 4'h0, 8'hAB);
        n_vec++;
        if (bus.pi_rd_data !== 8'hF5) begin n_err++; $display("FAIL wr_rd_conflict: got %h want F5", bus.pi_rd_data); end
        acc(1, 1, 0, 4'h1, 8'hCD);
        n_vec++;
        if (core_x !== 16'hCDAB) begin n_err++; $display("FAIL conflict_write: got %h want CDAB", core_x); end
        acc(0, 1, 0, 4'h1, 8'hEE);
        acc(0, 0, 1, 4'h7, 8'h00);
        n_vec++;
        if ({core_x, bus.pi_rd_data} !== {16'hCDAB, 8'hF5}) begin
            n_err++;
            $display("FAIL unselected: got x=%h rd=%h want x=CDAB rd=F5", core_x, bus.pi_rd_data);
        end
    endtask

    task automatic test_rdback();
        logic [7:0] e_lo, e_hi;
`ifdef UP_REG_RDBACK_EN
        e_lo = 8'h34; e_hi = 8'h12;
`else
        e_lo = 8'h00; e_hi = 8'h00;
`endif
        acc(1, 1, 0, 4'h0, 8'h34);
        acc(1, 1, 0, 4'h1, 8'h12);
        acc(1, 0, 1, 4'h0, 8'h00);
        n_vec++;
        if (bus.pi_rd_data !== e_lo) begin n_err++; $display("FAIL rdback_lo: got %h want %h", bus.pi_rd_data, e_lo); end
        acc(1, 0, 1, 4'h1, 8'h00);
        n_vec++;
        if (bus.pi_rd_data !== e_hi) begin n_err++; $display("FAIL rdback_hi: got %h want %h", bus.pi_rd_data, e_hi); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: acc(1, 1, 0, 4'($urandom), 8'($urandom));
                1: acc(1, 0, 1, 4'($urandom), 8'h00);
                2: eng(1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
                default: acc(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom_range(0, 7)), 8'($urandom));
            endcase
            n_vec++;
            if ({core_start, bus.interrupt, core_x, core_y, core_max_iter, bus.pi_rd_data} !==
                {m_start, m_irq, m_x, m_y, m_max, m_rdq}) begin
                n_err++;
                $display("FAIL random %0d: got start=%b irq=%b x=%h y=%h max=%h rd=%h want start=%b irq=%b x=%h y=%h max=%h rd=%h",
                         i, core_start, bus.interrupt, core_x, core_y, core_max_iter, bus.pi_rd_data,
                         m_start, m_irq, m_x, m_y, m_max, m_rdq);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        if (m_busy) eng(1, 8'h01, 1);
        acc(1, 1, 0, 4'h1, 8'h9A);
        acc(1, 1, 0, 4'h5, 8'h03);
        #3 rst_n = 1'b0;
        #1;
        m_reset();
        n_vec++;
        if ({core_start, bus.interrupt, core_x, core_y, core_max_iter, bus.pi_rd_data} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got start=%b irq=%b x=%h y=%h max=%h rd=%h want all 0",
                     core_start, bus.interrupt, core_x, core_y, core_max_iter, bus.pi_rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        eng(1, 8'h44, 0);
        acc(1, 0, 1, 4'h6, 8'h00);
        n_vec++;
        if ({core_start, bus.interrupt, bus.pi_rd_data} !== {1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL post_reset_idle: got start=%b irq=%b status=%h want 0 0 00",
                     core_start, bus.interrupt, bus.pi_rd_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pi_blk_sel = 0; bus.pi_wr_en = 0; bus.pi_rd_en = 0; bus.pi_addr = 0;
        bus.pi_wr_data = 0; bus.interrupt_ack = 0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_coords();
        test_start_done();
        test_irq_ack();
        test_start_err();
        test_bus_qualify();
        test_rdback();
        test_random();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fractal_up_regs.md
# fractal_up_regs

Byte-wide microprocessor register slave that terminates the fractal core's uP bus (block select, 4-bit address, 8-bit write/read data, interrupt/ack) and drives the fractal compute engine downstream. It assembles 16-bit X/Y coordinates from byte writes with atomic commit and issues a start pulse. It tracks engine run/done state, returns the iteration result and raises a level interrupt on completion until the host acknowledges it.

## Interface
Parameters:
- `ITER_W`, 8: width of max-iteration and result registers (≤ 8).
- `BLOCK_ID`, 8'hF5: constant returned at address 0xF.

Ports:
- `clk`  in  1  single system clock; all logic on posedge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `pi_blk_sel`  in  1  block select; qualifies all accesses.
- `pi_addr`  in  4  register address.
- `pi_wr_en`  in  1  write strobe, one cycle per access.
- `pi_rd_en`  in  1  read strobe, one cycle per access.
- `pi_wr_data`  in  8  write data.
- `pi_rd_data`  out  8  registered read data.
- `interrupt`  out  1  level interrupt to host.
- `interrupt_ack`  in  1  host acknowledge.
- `core_start`  out  1  one-cycle start pulse to engine.
- `core_x`  out  16  committed X coordinate.
- `core_y`  out  16  committed Y coordinate.
- `core_max_iter`  out  ITER_W  iteration limit.
- `core_done`  in  1  engine completion pulse.
- `core_iter`  in  ITER_W  engine result, valid with `core_done`.

## Operation
- Access occurs only when `pi_blk_sel`=1. `pi_wr_en` and `pi_rd_en` are never high together; if they are, write wins and `pi_rd_data` is unchanged.
- Register map (addr: name):
  - 0 X_LO (shadow)
  - 1 X_HI (writing commits {X_HI, shadow X_LO} to `core_x`)
  - 2 Y_LO (shadow)
  - 3 Y_HI (commits to `core_y`)
  - 4 MAX_ITER
  - 5 CTRL: bit0 start (write-1 self-clearing), bit1 irq_en
  - 6 STATUS (RO): bit0 busy, bit1 done, bit2 irq_pend, bit3 start_err
  - 7 RESULT (RO)
  - 0xF ID
  - All other addresses read 0; writes to them are ignored.
- FSM states:
  - IDLE → RUN on CTRL write with bit0=1; `core_start` pulses; done cleared.
  - RUN → DONE on `core_done`; RESULT latches `core_iter`; done=1.
  - DONE → RUN on a new start.
- A start received in RUN is dropped and sets sticky start_err. Writing CTRL with bit0=0 clears start_err.
- busy=1 only in RUN.
- irq_pend sets on `core_done` when irq_en=1. It clears the cycle after `interrupt_ack` is sampled high. `interrupt` = irq_pend.
- If ack and a new `core_done` coincide, set wins.
- Clearing irq_en does not clear a pending interrupt.
- `core_done` outside RUN is ignored.

## Timing
- Reset values: `pi_rd_data`=0, `interrupt`=0, `core_start`=0, `core_x`=0, `core_y`=0, `core_max_iter`=0, RESULT=0, shadows=0, CTRL=0, FSM=IDLE.
- Write takes effect on the clk edge sampling `pi_wr_en`. `core_x`/`core_y` update on that same edge for HI writes.
- `core_start` is high for exactly the one cycle after the start write edge; FSM=RUN from that cycle.
- Read: `pi_rd_data` is valid the cycle after `pi_rd_en` is sampled and holds until the next read.
- `interrupt` rises 1 cycle after `core_done` and falls 1 cycle after `interrupt_ack`.
- Reset mid-RUN: FSM returns to IDLE immediately. Engine outputs are held at 0; no further start issues.

## Configuration
- `UP_REG_RDBACK_EN`:
  - Defined: addresses 0–3 read back committed `core_x`/`core_y` bytes (LO: [7:0], HI: [15:8]) and address 4 reads MAX_ITER.
  - Undefined: addresses 0–4 are write-only and read 0.

## Test plan
- Reset, then read all of 0x0–0xF → only 0xF returns 0xF5; `interrupt`=0.
- Write X_LO=0x34, check `core_x`=0; write X_HI=0x12 → `core_x`=0x1234 the same edge.
- Write CTRL=0x03 → `core_start` high one cycle. STATUS=0x01; pulse `core_done` with `core_iter`=0x2A → `interrupt`=1 next cycle, RESULT=0x2A, STATUS=0x06.
- Assert `interrupt_ack` → `interrupt`=0 next cycle. Ack coincident with a fresh `core_done` → `interrupt` stays 1.
- Write CTRL=0x01 while busy → no `core_start`, STATUS bit3=1. Write CTRL=0x00 → bit3 clears.
- With `UP_REG_RDBACK_EN`, after X=0x1234 read addr 0 → 0x34, addr 1 → 0x12. Without the macro, both read 0.
